// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared opcodes, state encodings and mux codes for the multicycle MIPS control
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_SEXT    = 2'b10;
  localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that own the shared memory port and wait on mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// rtl/multicycle_ctrl_mem_wait_timer.sv - memory wait-state counter with timeout compare
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = (wait_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM sequencing fetch, decode and execute steps of the multicycle MIPS datapath
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  state_t state, state_next;
  logic   expired;
  logic   timer_clear;

  // The counter restarts whenever a memory state is entered or left
  assign timer_clear = !is_mem_state(state) || (state_next != state);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .inc    (!mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (expired) state_next = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
                else if (expired) state_next = S_TRAP;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
                else if (expired) state_next = S_TRAP;
      S_EXEC:   state_next = S_RTWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    bus_error     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = ALUB_SEXT_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SEXT;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_TRAP:   bus_error = 1'b1;
      default:  bus_error = 1'b1;
    endcase
    // FETCH is the reset state, so its memory strobe must be masked while reset is held
    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      bus_error     = 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against a cycle-script model
module tb_multicycle_ctrl;

  localparam int TO = 15;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3,
                         ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6, ST_RTWB = 4'd7,
                         ST_BRANCH = 4'd8, ST_JUMP = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11,
                         ST_TRAP = 4'd15;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, bus_error;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       bus_error;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic [3:0] st;
    logic [5:0] op;
  } rec_t;

  outs_t dut_outs;
  rec_t  script[$];
  int    errors = 0;
  int    checks = 0;
  int    len;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .bus_error(bus_error), .state_dbg(state_dbg)
  );

  assign dut_outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, bus_error};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output vector and the mask of fields the state actually defines
  task automatic expect_for(input logic [3:0] st, input logic rdy, output outs_t e, output outs_t c);
    e = '0;
    c = '0;
    {c.pc_write, c.pc_write_cond, c.mem_read, c.mem_write, c.ir_write, c.reg_write, c.bus_error} = '1;
    case (st)
      ST_FETCH: begin
        e.mem_read = 1'b1; e.pc_write = rdy; e.ir_write = rdy; e.alu_src_b = 2'b01;
        c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1; c.pc_source = '1;
      end
      ST_DECODE: begin
        e.alu_src_b = 2'b11;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      ST_MEMADR, ST_ADDIEX: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      ST_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; c.iord = 1'b1; end
      ST_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; c.iord = 1'b1; end
      ST_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; c.mem_to_reg = 1'b1; c.reg_dst = 1'b1; end
      ST_EXEC: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      ST_RTWB:   begin e.reg_write = 1'b1; e.reg_dst = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1; end
      ST_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_source = 2'b01;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1; c.pc_source = '1;
      end
      ST_JUMP:   begin e.pc_write = 1'b1; e.pc_source = 2'b10; c.pc_source = '1; end
      ST_ADDIWB: begin e.reg_write = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1; end
      ST_TRAP:   e.bus_error = 1'b1;
      default:   e.bus_error = 1'b1;
    endcase
  endtask

  task automatic add(input logic rdy, input logic [3:0] st, input logic [5:0] op);
    rec_t r;
    r.rdy = rdy; r.st = st; r.op = op;
    script.push_back(r);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction as a cycle script: wf wait cycles in FETCH, wm in the data access
  task automatic gen_instr(input logic [5:0] op, input int wf, input int wm, output int n);
    int n0;
    n0 = script.size();
    repeat (wf) add(1'b0, ST_FETCH, op);
    add(1'b1, ST_FETCH, op);
    add(rnd_bit(), ST_DECODE, op);
    case (op)
      LW: begin
        add(rnd_bit(), ST_MEMADR, op);
        repeat (wm) add(1'b0, ST_MEMRD, op);
        add(1'b1, ST_MEMRD, op);
        add(rnd_bit(), ST_MEMWB, op);
      end
      SW: begin
        add(rnd_bit(), ST_MEMADR, op);
        repeat (wm) add(1'b0, ST_MEMWR, op);
        add(1'b1, ST_MEMWR, op);
      end
      RT:   begin add(rnd_bit(), ST_EXEC, op); add(rnd_bit(), ST_RTWB, op); end
      ADDI: begin add(rnd_bit(), ST_ADDIEX, op); add(rnd_bit(), ST_ADDIWB, op); end
      BEQ:  add(rnd_bit(), ST_BRANCH, op);
      JMP:  add(rnd_bit(), ST_JUMP, op);
      default: repeat (3) add(rnd_bit(), ST_TRAP, op);
    endcase
    n = script.size() - n0;
  endtask

  task automatic run_script();
    rec_t  r;
    outs_t e, c;
    while (script.size() > 0) begin
      r = script.pop_front();
      @(negedge clk);
      opcode = r.op;
      mem_ready = r.rdy;
      #1;
      check($sformatf("state(exp %0d)", r.st), 32'(state_dbg), 32'(r.st));
      expect_for(r.st, r.rdy, e, c);
      check($sformatf("outs@state%0d", r.st), 32'(dut_outs & c), 32'(e & c));
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_FETCH));
    check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_bus_error"}, 32'(bus_error), 32'd0);
    check({tag, "_enables"}, 32'({pc_write, pc_write_cond, ir_write, reg_write}), 32'd0);
  endtask

  // Assert reset between edges, check at once, release just after an edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    mem_ready = 1'b0;
    #1 check_in_reset(tag);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [5:0] ops[6];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;

    #2 reset = 1'b0;
    #1 check_in_reset("por");
    @(posedge clk);
    #2 reset = 1'b1;

    // R-type, lw with 3 MEMRD waits, then sw / beq / j back to back
    gen_instr(RT, 0, 0, len);   check("len_rtype", 32'(len), 32'd4);
    gen_instr(LW, 0, 3, len);   check("len_lw_wait3", 32'(len), 32'd8);
    gen_instr(SW, 0, 0, len);   check("len_sw", 32'(len), 32'd4);
    gen_instr(BEQ, 0, 0, len);  check("len_beq", 32'(len), 32'd3);
    gen_instr(JMP, 0, 0, len);  check("len_j", 32'(len), 32'd3);
    gen_instr(LW, 0, 0, len);   check("len_lw", 32'(len), 32'd5);
    gen_instr(ADDI, 0, 0, len); check("len_addi", 32'(len), 32'd4);
    gen_instr(LW, TO, TO, len);
    gen_instr(SW, 2, TO, len);
    run_script();

    // Fetch never acknowledged: TRAP after TO+1 cycles, sticky regardless of mem_ready
    repeat (TO + 1) add(1'b0, ST_FETCH, RT);
    repeat (5) add(rnd_bit(), ST_TRAP, RT);
    run_script();
    do_reset("rst_trap");

    gen_instr(BAD, 1, 0, len);
    run_script();
    do_reset("rst_bad");

    // Data-read timeout
    add(1'b1, ST_FETCH, LW); add(1'b0, ST_DECODE, LW); add(1'b0, ST_MEMADR, LW);
    repeat (TO + 1) add(1'b0, ST_MEMRD, LW);
    repeat (2) add(1'b1, ST_TRAP, LW);
    run_script();
    do_reset("rst_rdto");

    // Reset while a store is waiting on the bus
    add(1'b1, ST_FETCH, SW); add(1'b1, ST_DECODE, SW); add(1'b1, ST_MEMADR, SW);
    add(1'b0, ST_MEMWR, SW); add(1'b0, ST_MEMWR, SW);
    run_script();
    do_reset("rst_memwr");
    gen_instr(RT, 0, 0, len);
    run_script();

    for (int i = 0; i < 40; i++) begin
      int wf, wm;
      wf = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 4));
      wm = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 4));
      gen_instr(ops[$urandom_range(0, 5)], wf, wm, len);
    end
    run_script();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
